// File: rtl/uart_boot_loader_if.sv
// Bundles the UART RX strobe, reload, instruction-memory write port and core-control outputs of the boot loader.
// master = loader side, slave = environment (UART, memory, core).
interface uart_boot_loader_if #(
  parameter int MEM = 10
);
  logic           rx_valid;
  logic [7:0]     rdata;
  logic           reload;
  logic           imem_we;
  logic [MEM-3:0] imem_addr;
  logic [31:0]    imem_din;
  logic           core_rstn;
  logic           busy;
  logic           err;

  modport master (
    input  rx_valid, rdata, reload,
    output imem_we, imem_addr, imem_din, core_rstn, busy, err
  );

  modport slave (
    output rx_valid, rdata, reload,
    input  imem_we, imem_addr, imem_din, core_rstn, busy, err
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Boot loader: holds the core in reset, packs a little-endian UART image into instruction memory, then releases the core.
// Optional trailing XOR checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int MEM       = 10,
  parameter int LOAD_BASE = 32
) (
  input  logic              clk,
  input  logic              rstn,
  uart_boot_loader_if.master bus
);
  localparam int          AW    = MEM - 2;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] CAP   = 32'(DEPTH - LOAD_BASE);
  localparam logic [AW-1:0] BASE_ADDR = AW'(LOAD_BASE);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_LEN, S_DATA, S_RUN} state_t;
`endif

  state_t        r_state, w_state_next;
  logic [1:0]    r_bidx, w_bidx_next;
  logic [31:0]   r_len, w_len_next;
  logic [31:0]   r_word, w_word_next;
  logic [31:0]   r_cnt, w_cnt_next;
  logic          r_we, w_we_next;
  logic [AW-1:0] r_addr, w_addr_next;
  logic [31:0]   r_din, w_din_next;
  logic          r_core_rstn, w_core_rstn_next;
  logic          r_busy, w_busy_next;
  logic [31:0]   w_len_shift, w_word_shift;
  state_t        w_done_state;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]    r_csum, w_csum_next;
  logic          r_err, w_err_next;
`endif

  // Bytes arrive LSB first, so each new byte enters at the top and slides down.
  assign w_len_shift  = {bus.rdata, r_len[31:8]};
  assign w_word_shift = {bus.rdata, r_word[31:8]};
`ifdef BOOT_CHECKSUM_EN
  assign w_done_state = S_CSUM;
`else
  assign w_done_state = S_RUN;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_LEN;
      r_bidx      <= 2'd0;
      r_len       <= 32'd0;
      r_word      <= 32'd0;
      r_cnt       <= 32'd0;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_din       <= 32'd0;
      r_core_rstn <= 1'b0;
      r_busy      <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      r_csum      <= 8'd0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_bidx      <= w_bidx_next;
      r_len       <= w_len_next;
      r_word      <= w_word_next;
      r_cnt       <= w_cnt_next;
      r_we        <= w_we_next;
      r_addr      <= w_addr_next;
      r_din       <= w_din_next;
      r_core_rstn <= w_core_rstn_next;
      r_busy      <= w_busy_next;
`ifdef BOOT_CHECKSUM_EN
      r_csum      <= w_csum_next;
      r_err       <= w_err_next;
`endif
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_bidx_next      = r_bidx;
    w_len_next       = r_len;
    w_word_next      = r_word;
    w_cnt_next       = r_cnt;
    w_we_next        = 1'b0;
    w_addr_next      = r_addr;
    w_din_next       = r_din;
    // Release lags entry into S_RUN by one edge so it never precedes the last write.
    w_core_rstn_next = (r_state == S_RUN);
    w_busy_next      = (r_state != S_RUN);
`ifdef BOOT_CHECKSUM_EN
    w_csum_next      = r_csum;
    w_err_next       = (r_state == S_ERR);
    w_busy_next      = (r_state != S_RUN) && (r_state != S_ERR);
`endif

    if (bus.reload) begin
      w_state_next     = S_LEN;
      w_bidx_next      = 2'd0;
      w_len_next       = 32'd0;
      w_word_next      = 32'd0;
      w_cnt_next       = 32'd0;
      w_addr_next      = BASE_ADDR;
      w_core_rstn_next = 1'b0;
      w_busy_next      = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      w_csum_next      = 8'd0;
      w_err_next       = 1'b0;
`endif
    end else if (bus.rx_valid) begin
      case (r_state)
        S_LEN: begin
          w_len_next  = w_len_shift;
          w_bidx_next = r_bidx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          w_csum_next = r_csum ^ bus.rdata;
`endif
          if (r_bidx == 2'd3)
            w_state_next = (w_len_shift == 32'd0) ? w_done_state : S_DATA;
        end
        S_DATA: begin
          w_word_next = w_word_shift;
          w_bidx_next = r_bidx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          w_csum_next = r_csum ^ bus.rdata;
`endif
          if (r_bidx == 2'd3) begin
            // Words past the end of memory are counted so the image still completes.
            if (r_cnt < CAP) begin
              w_we_next   = 1'b1;
              w_addr_next = BASE_ADDR + r_cnt[AW-1:0];
              w_din_next  = w_word_shift;
            end
            w_cnt_next = r_cnt + 32'd1;
            if (r_cnt + 32'd1 == r_len)
              w_state_next = w_done_state;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CSUM: w_state_next = (bus.rdata == r_csum) ? S_RUN : S_ERR;
`endif
        default: ;
      endcase
    end
  end

  assign bus.imem_we   = r_we;
  assign bus.imem_addr = r_addr;
  assign bus.imem_din  = r_din;
  assign bus.core_rstn = r_core_rstn;
  assign bus.busy      = r_busy;
`ifdef BOOT_CHECKSUM_EN
  assign bus.err       = r_err;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes are queued at stimulus time, a monitor pops them on every imem_we.
// Checksum scenarios run only when BOOT_CHECKSUM_EN is defined.
module tb_uart_boot_loader;
  localparam int MEM       = 10;
  localparam int LOAD_BASE = 32;
  localparam int CAP       = (1 << (MEM - 2)) - LOAD_BASE;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.MEM(MEM)) bus ();
  uart_boot_loader #(.MEM(MEM), .LOAD_BASE(LOAD_BASE)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [MEM-3:0] addr;
    logic [31:0]    data;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         exp_q[$];
  logic [31:0] img_q[$];
  logic [7:0]  tb_csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rstn && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write", bus.imem_addr, bus.imem_din);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("write_data", bus.imem_din, e.data);
        $display("[TB] write addr %0d data 0x%08h", bus.imem_addr, bus.imem_din);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rdata    = b;
    tb_csum      = tb_csum ^ b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  // Core must still be in reset in the cycle after the last byte, released the cycle after that.
  task automatic check_release(input string name);
    @(negedge clk);
    check({name, "_rstn_hold"}, 32'(bus.core_rstn), 32'd0);
    @(negedge clk);
    check({name, "_rstn_rel"}, 32'(bus.core_rstn), 32'd1);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_err"}, 32'(bus.err), 32'd0);
    $display("[TB] %s released core", name);
    @(posedge clk); #1;
  endtask

  task automatic send_image(input string name, input int n, input bit bad_csum);
    logic [31:0] w;
    logic [31:0] len;
    wr_t         e;
    tb_csum = 8'd0;
    len = 32'(n);
    for (int b = 0; b < 4; b++) send_byte(len[8*b +: 8]);
    for (int i = 0; i < img_q.size(); i++) begin
      w = img_q[i];
      if (i < CAP) begin
        e.addr = (MEM-2)'(LOAD_BASE + i);
        e.data = w;
        exp_q.push_back(e);
      end
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(bad_csum ? ~tb_csum : tb_csum);
    if (bad_csum) begin
      @(negedge clk);
      @(negedge clk);
      check({name, "_err"}, 32'(bus.err), 32'd1);
      check({name, "_rstn"}, 32'(bus.core_rstn), 32'd0);
      check({name, "_busy"}, 32'(bus.busy), 32'd0);
      $display("[TB] %s checksum rejected", name);
      @(posedge clk); #1;
      return;
    end
`endif
    check_release(name);
  endtask

  task automatic pulse_reload(input string name);
    bus.reload = 1'b1;
    @(posedge clk); #1;
    bus.reload = 1'b0;
    @(negedge clk);
    check({name, "_rstn"}, 32'(bus.core_rstn), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    check({name, "_addr"}, 32'(bus.imem_addr), 32'(LOAD_BASE));
    $display("[TB] %s reload", name);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rdata    = 8'd0;
    bus.reload   = 1'b0;
    tb_csum      = 8'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_we",   32'(bus.imem_we),   32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'(LOAD_BASE));
    check("rst_din",  bus.imem_din,       32'd0);
    check("rst_rstn", 32'(bus.core_rstn), 32'd0);
    check("rst_busy", 32'(bus.busy),      32'd1);
    check("rst_err",  32'(bus.err),       32'd0);
    $display("[TB] reset values checked");
    @(posedge clk); #1;

    // Two-word image from the reference vector.
    img_q = '{32'h0000_0013, 32'h0010_0093};
    send_image("n2", 2, 1'b0);

    // Bytes in S_RUN are ignored: no write, core stays released.
    for (int i = 0; i < 8; i++) send_byte(8'hAA);
    @(negedge clk);
    check("run_ignore_rstn", 32'(bus.core_rstn), 32'd1);
    @(posedge clk); #1;

    pulse_reload("rl1");
    img_q = '{32'hDEAD_BEEF};
    send_image("reload_n1", 1, 1'b0);

    pulse_reload("rl2");
    img_q = {};
    send_image("n0", 0, 1'b0);

    // Reload coinciding with a byte: the byte is dropped.
    bus.reload   = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rdata    = 8'h07;
    @(posedge clk); #1;
    bus.reload   = 1'b0;
    bus.rx_valid = 1'b0;
    img_q = '{32'hA5A5_0001};
    send_image("drop", 1, 1'b0);

    // Reset mid-length discards the partial length.
    pulse_reload("rl3");
    tb_csum = 8'd0;
    send_byte(8'h05);
    send_byte(8'h00);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    img_q = '{32'h1234_5678};
    send_image("rst_mid", 1, 1'b0);

    // Overflow: 226 words, only 224 fit at 32..255.
    pulse_reload("rl4");
    img_q = {};
    for (int i = 0; i < 226; i++) img_q.push_back(32'(i) * 32'h0101_0101 ^ 32'hC0DE_0000);
    send_image("ovf", 226, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    pulse_reload("rl5");
    img_q = '{32'h0000_0013};
    send_image("csum_bad", 1, 1'b1);
    pulse_reload("rl6");
    img_q = '{32'h0000_0013};
    send_image("csum_good", 1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
